sweep_scheduler: RTL and testbench
==================================

SWEEP_SCHEDULER -- requirements
Module: sweep_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requester channels, fixed at 4 for this release.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 4, meaning the maximum number of queued plus running sweeps.
REQ-003 SHALL have port clk, input, 1 bit: the single 50 MHz clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: channel i holds an instruction pending.
REQ-006 SHALL have port req_data, input, 80*NUM_REQ bits: channel i instruction at [80*i+79:80*i], laid out as init_freq[79:48], cycles_per_step[47:32], freq_step[31:0].
REQ-007 SHALL have port req_ack, output, NUM_REQ bits: one-hot single-cycle pulse when channel i's instruction is written.
REQ-008 SHALL have port fifo_full, input, 1 bit: the instruction FIFO cannot accept a write.
REQ-009 SHALL have port fifo_wr_en, output, 1 bit: single-cycle write strobe.
REQ-010 SHALL have port fifo_wdata, output, 80 bits: the instruction being written.
REQ-011 SHALL have port sweep_start, input, 1 bit: single-cycle pulse from the sweeper when a sweep begins.
REQ-012 SHALL have port sweep_done, input, 1 bit: single-cycle pulse from the sweeper when a sweep ends.
REQ-013 SHALL have port active_owner, output, 2 bits: the channel that owns the running sweep.
REQ-014 SHALL have port owner_valid, output, 1 bit: active_owner is meaningful.
REQ-015 SHALL have port done_vec, output, NUM_REQ bits: one-hot pulse marking the channel whose sweep completed.
REQ-016 SHALL have port inflight, output, 3 bits: count of instructions written but not yet done.
REQ-017 SHALL have port err_underflow, output, 1 bit: sticky flag for sweep_done arriving with inflight equal to 0.

Function
REQ-018 SHALL run a two-state FSM: ARB and WRITE.
REQ-019 In ARB, the FSM SHALL grant only when all of these hold: req_valid is non-zero, fifo_full is 0, and inflight < MAX_INFLIGHT.
- On a grant it SHALL register the winner index and that channel's req_data.
- It SHALL then go to WRITE; otherwise it SHALL stay in ARB.
REQ-020 Arbitration SHALL be round-robin.
- Search starts at (last_grant+1) mod NUM_REQ.
- last_grant resets to NUM_REQ-1, so channel 0 has first priority.
REQ-021 In WRITE, the block SHALL do all of the following for exactly one cycle, then return to ARB:
- assert fifo_wr_en;
- drive fifo_wdata with the registered data;
- pulse req_ack[winner];
- push the winner onto the tag queue.
REQ-022 Latency SHALL be one cycle from a granting ARB cycle to fifo_wr_en/req_ack, giving at most one write per 2 cycles.
REQ-023 A requester SHALL hold req_valid and req_data stable until it sees req_ack.
- If req_valid drops after the grant, the write still occurs with the registered data.
REQ-024 fifo_full SHALL be sampled only in ARB; this block is the FIFO's sole writer.
REQ-025 The tag queue SHALL be a FIFO of 2-bit channel indices, depth MAX_INFLIGHT, kept in the same order as the instruction FIFO.
REQ-026 On sweep_start, owner_valid SHALL be 1 and active_owner SHALL be the queue head, both registered on the next edge.
REQ-027 On sweep_done with inflight > 0, the block SHALL take these actions on the next edge:
- pulse done_vec[head];
- pop the queue;
- clear owner_valid.
REQ-028 inflight SHALL increment on a WRITE cycle and decrement on an accepted sweep_done.
- If both occur in the same cycle, inflight is unchanged and the queue pushes and pops at once.
REQ-029 If sweep_done arrives with inflight equal to 0, the block SHALL:
- set err_underflow, which is cleared only by reset;
- leave the queue and counter unchanged;
- leave done_vec at 0.
REQ-030 If sweep_start arrives with inflight equal to 0, the block SHALL ignore it, leaving owner_valid unchanged.
REQ-031 inflight SHALL never exceed MAX_INFLIGHT; the grant condition in REQ-019 guarantees this.

Reset
REQ-032 While reset is high, the block SHALL hold the following values asynchronously:
- FSM in ARB;
- fifo_wr_en, req_ack, done_vec, owner_valid and err_underflow at 0;
- fifo_wdata at 0 and active_owner at 0;
- inflight at 0, tag queue empty, last_grant at NUM_REQ-1.
REQ-033 Reset asserted mid-WRITE SHALL suppress the write: no fifo_wr_en and no req_ack.

Verification
REQ-034 Single request: req_valid=0001, data=0x00001000_0004_00000010 -> fifo_wr_en one cycle later with that data; req_ack=0001; inflight=1.
REQ-035 Contention: req_valid=1111 held -> grant order 0,1,2,3, then stop at inflight=4; req_ack pulses every 2 cycles; no write while inflight=4.
REQ-036 Backpressure: fifo_full=1 with req_valid=0010 -> no write; fifo_full falls -> write within 2 cycles.
REQ-037 Ownership: channels 2 then 0 written; sweep_start -> active_owner=2, owner_valid=1; sweep_done -> done_vec=0100, inflight decrements; next start -> active_owner=0.
REQ-038 Simultaneous WRITE and sweep_done -> inflight unchanged, queue order preserved; sweep_done with inflight=0 -> err_underflow=1, done_vec=0.
REQ-039 Reset during WRITE -> no fifo_wr_en and no req_ack; all outputs at their REQ-032 values.

Source files
------------

// File: rtl/sweep_scheduler.sv
// Sweep scheduler: round-robin arbiter that writes sweep instructions from
// NUM_REQ channels into the instruction FIFO. A tag queue records which
// channel owns each queued sweep, so that start/done events from the
// sweeper can be attributed to the right channel.
module sweep_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [80*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ack,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [79:0]            fifo_wdata,
  input  logic                   sweep_start,
  input  logic                   sweep_done,
  output logic [1:0]             active_owner,
  output logic                   owner_valid,
  output logic [NUM_REQ-1:0]     done_vec,
  output logic [2:0]             inflight,
  output logic                   err_underflow
);

  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {ARB, WRITE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      last_q, win_q;
  logic [79:0]     data_q;
  logic [1:0]      tag_q [MAX_INFLIGHT];
  logic [PW-1:0]   rd_q, wr_q;
  logic [2:0]      inflight_q;
  logic [1:0]      owner_q;
  logic            owner_valid_q, err_q;
  logic [NUM_REQ-1:0] done_q;

  logic            gnt_found, grant, wr, done_acc, start_acc;
  logic [1:0]      gnt_idx, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head      = tag_q[rd_q];
  assign wr        = (state_q == WRITE);
  assign done_acc  = sweep_done  && (inflight_q != 3'd0);
  assign start_acc = sweep_start && (inflight_q != 3'd0);

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = 2'(idx);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ARB;
    else       state_q <= state_d;
  end

  // Next state and write-side outputs; the write lasts exactly one cycle.
  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    fifo_wr_en = 1'b0;
    req_ack    = '0;
    case (state_q)
      ARB: begin
        grant = gnt_found && !fifo_full && (inflight_q < 3'(MAX_INFLIGHT));
        if (grant) state_d = WRITE;
      end
      WRITE: begin
        fifo_wr_en = 1'b1;
        req_ack    = ONE << win_q;
        state_d    = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  assign fifo_wdata = data_q;

  // Grant capture: winner and its instruction are held for the WRITE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 2'(NUM_REQ - 1);
      win_q  <= '0;
      data_q <= '0;
    end else if (grant) begin
      last_q <= gnt_idx;
      win_q  <= gnt_idx;
      data_q <= req_data[80*int'(gnt_idx) +: 80];
    end
  end

  // Tag queue and inflight counter; push and pop may happen together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_INFLIGHT; i++) tag_q[i] <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      inflight_q <= '0;
    end else begin
      if (wr) begin
        tag_q[wr_q] <= win_q;
        wr_q        <= ptr_inc(wr_q);
      end
      if (done_acc) rd_q <= ptr_inc(rd_q);
      case ({wr, done_acc})
        2'b10:   inflight_q <= inflight_q + 3'd1;
        2'b01:   inflight_q <= inflight_q - 3'd1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Ownership tracking, completion pulse and sticky underflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      done_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      done_q <= done_acc ? (ONE << head) : '0;
      if (done_acc) begin
        owner_valid_q <= 1'b0;
      end else if (start_acc) begin
        owner_valid_q <= 1'b1;
        owner_q       <= head;
      end
      if (sweep_done && inflight_q == 3'd0) err_q <= 1'b1;
    end
  end

  assign active_owner  = owner_q;
  assign owner_valid   = owner_valid_q;
  assign done_vec      = done_q;
  assign inflight      = inflight_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_sweep_scheduler.sv
// Randomized bench for sweep_scheduler against a transaction-level model:
// requesters, FIFO backpressure and sweeper events are random; the model
// keeps the owner queue as an int queue and arbitrates by plain search.
module tb_sweep_scheduler;

  localparam int NR = 4;
  localparam int MI = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [80*NR-1:0]  req_data;
  logic [NR-1:0]     req_ack;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [79:0]       fifo_wdata;
  logic              sweep_start, sweep_done;
  logic [1:0]        active_owner;
  logic              owner_valid;
  logic [NR-1:0]     done_vec;
  logic [2:0]        inflight;
  logic              err_underflow;

  sweep_scheduler #(.NUM_REQ(NR), .MAX_INFLIGHT(MI)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wdata(fifo_wdata), .sweep_start(sweep_start), .sweep_done(sweep_done),
    .active_owner(active_owner), .owner_valid(owner_valid), .done_vec(done_vec),
    .inflight(inflight), .err_underflow(err_underflow)
  );

  always #10 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Model state
  bit          m_wr;
  int          m_win, m_last, m_owner, m_done;
  logic [79:0] m_wdata;
  bit          m_ov, m_err;
  int          q[$];
  bit          rv[NR];
  logic [79:0] rd[NR];

  task automatic model_reset();
    m_wr = 0; m_win = 0; m_last = NR - 1; m_owner = 0; m_done = 0;
    m_wdata = '0; m_ov = 0; m_err = 0; q.delete();
    for (int c = 0; c < NR; c++) begin rv[c] = 0; rd[c] = '0; end
  endtask

  task automatic drive();
    for (int c = 0; c < NR; c++) begin
      req_valid[c] = rv[c];
      req_data[80*c +: 80] = rd[c];
    end
  endtask

  task automatic check_outputs();
    chk("wr_en", fifo_wr_en, m_wr);
    chk("req_ack", req_ack, m_wr ? (80'd1 << m_win) : 80'd0);
    if (m_wr) chk("wdata", fifo_wdata, m_wdata);
    chk("inflight", inflight, q.size());
    chk("owner_valid", owner_valid, m_ov);
    if (m_ov) chk("active_owner", active_owner, m_owner);
    chk("done_vec", done_vec, m_done);
    chk("err_underflow", err_underflow, m_err);
  endtask

  task automatic check_reset_vals();
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_wdata", fifo_wdata, 0);
    chk("rst_owner", active_owner, 0);
    chk("rst_ov", owner_valid, 0);
    chk("rst_done", done_vec, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err_underflow, 0);
  endtask

  // Asserted at a negedge: outputs must clear at once, even mid-write.
  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    drive();
    fifo_full = 0; sweep_start = 0; sweep_done = 0;
    #1 check_reset_vals();
    @(posedge clk);
    @(negedge clk);
    #1 check_reset_vals();
    reset = 1'b0;
  endtask

  initial begin
    bit want_rst;
    int old_size, head, r;
    bit any;
    reset = 1'b1; req_valid = '0; req_data = '0; fifo_full = 0;
    sweep_start = 0; sweep_done = 0;
    model_reset();
    repeat (2) @(negedge clk);
    apply_reset();
    want_rst = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check_outputs();
      if (cyc == 1200 || cyc == 2600) want_rst = 1;
      if (want_rst && m_wr) begin
        want_rst = 0;
        apply_reset();
        continue;
      end
      // Requesters: drop after ack, randomly raise new instructions.
      if (m_wr) rv[m_win] = 0;
      for (int c = 0; c < NR; c++)
        if (!rv[c] && ($urandom % 4 == 0)) begin
          rv[c] = 1;
          rd[c] = {$urandom, 16'($urandom), $urandom};
        end
      drive();
      fifo_full = ($urandom % 4 == 0);
      r = $urandom % 8;
      sweep_start = (r == 0);
      sweep_done  = (r == 1) && (q.size() > 0 || ($urandom % 16 == 0));
      // Model update for the coming edge.
      old_size = q.size();
      head = (old_size > 0) ? q[0] : 0;
      m_done = 0;
      if (sweep_done) begin
        if (old_size > 0) begin
          m_done = 1 << head;
          void'(q.pop_front());
          m_ov = 0;
        end else m_err = 1;
      end else if (sweep_start && old_size > 0) begin
        m_ov = 1;
        m_owner = head;
      end
      if (m_wr) begin
        q.push_back(m_win);
        m_wr = 0;
      end else if (!fifo_full && old_size < MI) begin
        any = 0;
        for (int k = 1; k <= NR; k++) begin
          int c;
          c = (m_last + k) % NR;
          if (!any && rv[c]) begin
            any = 1; m_wr = 1; m_win = c; m_wdata = rd[c]; m_last = c;
          end
        end
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
